// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall/flush, next-PC selection,
// EPC capture, HALT on reserved instruction, and saturating stall/redirect counters.
module pipe_hazard_ctrl #(
  parameter int          NSTAGE     = 4,
  parameter int          REG_AW     = 5,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] EXC_VECTOR = 32'h80000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_jmp,
  input  logic              mem_jr,
  input  logic              mem_branch_state,
  input  logic              mem_stall,
  input  logic [31:0]       mem_excepttype,
  input  logic [31:0]       mem_pc,
  input  logic              idex_mem_r,
  input  logic [REG_AW-1:0] ifid_rs_addr,
  input  logic [REG_AW-1:0] ifid_rt_addr,
  input  logic [REG_AW-1:0] idex_rd_addr,
  input  logic              resume,
  input  logic              cnt_clr,
  output logic [NSTAGE:0]   stall,
  output logic [NSTAGE-1:0] flush,
  output logic [2:0]        pc_src,
  output logic [31:0]       vector,
  output logic [31:0]       epc,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redir_cnt
);

  localparam int SW = NSTAGE + 1;

  localparam logic [2:0] PC_JUMP   = 3'd0;
  localparam logic [2:0] PC_EXCEPT = 3'd1;
  localparam logic [2:0] PC_ERET   = 3'd2;
  localparam logic [2:0] PC_CTRL   = 3'd3;
  localparam logic [2:0] PC_SEQ    = 3'd4;

  localparam logic [31:0] CODE_ERET = 32'h0000000D;
  localparam logic [31:0] CODE_RI   = 32'h0000000A;

  // Exceptions flush everything younger than MEM; control hazards only the front two.
  localparam logic [NSTAGE-1:0] EXC_FLUSH = {1'b0, {(NSTAGE-1){1'b1}}};
  localparam logic [NSTAGE-1:0] CH_FLUSH  = NSTAGE'(2'b11);
  localparam logic [NSTAGE-1:0] LU_FLUSH  = NSTAGE'(2'b10);
  localparam logic [SW-1:0]     LU_STALL  = SW'(2'b11);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   epc_load;
  logic   load_use;
  logic   redir;

  assign load_use = idex_mem_r && (idex_rd_addr != '0) &&
                    ((ifid_rs_addr == idex_rd_addr) || (ifid_rt_addr == idex_rd_addr));

  assign halted = (state == ST_HALT);
  assign redir  = (pc_src == PC_EXCEPT) || (pc_src == PC_ERET) || (pc_src == PC_CTRL);

  always_comb begin
    stall     = '0;
    flush     = '0;
    pc_src    = PC_SEQ;
    vector    = '0;
    state_nxt = state;
    epc_load  = 1'b0;
    if (reset) begin
      flush = '1;
    end else if (state == ST_HALT) begin
      if (resume) begin
        pc_src    = PC_EXCEPT;
        vector    = EXC_VECTOR;
        flush     = EXC_FLUSH;
        state_nxt = ST_RUN;
      end else begin
        stall = '1;
      end
    end else if (mem_stall) begin
      // Any pending exception stays in MEM and is taken once the stall drops.
      stall = '1;
    end else if (mem_excepttype == CODE_ERET) begin
      pc_src = PC_ERET;
      vector = epc;
      flush  = EXC_FLUSH;
    end else if (mem_excepttype == CODE_RI) begin
      epc_load  = 1'b1;
      flush     = EXC_FLUSH;
      stall[0]  = 1'b1;
      state_nxt = ST_HALT;
    end else if (mem_excepttype != '0) begin
      pc_src   = PC_EXCEPT;
      vector   = EXC_VECTOR;
      flush    = EXC_FLUSH;
      epc_load = 1'b1;
    end else if (mem_branch_state || mem_jr) begin
      pc_src = PC_CTRL;
      flush  = CH_FLUSH;
    end else if (id_jmp) begin
      pc_src = PC_JUMP;
    end else if (load_use) begin
      stall = LU_STALL;
      flush = LU_FLUSH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      epc       <= '0;
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (epc_load) epc <= mem_pc;
      if (cnt_clr) begin
        stall_cnt <= '0;
        redir_cnt <= '0;
      end else begin
        if (stall[0] && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        if (redir && (redir_cnt != '1))    redir_cnt <= redir_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard/exception controller for the pipelined CPU; successor to the single-shot combinational control unit. Generates per-stage stall and flush vectors and next-PC source/vector for an NSTAGE-register pipeline. Adds exception PC capture (EPC), a HALT state for reserved-instruction exceptions released by `resume`, zero-register-aware load-use detection, and saturating stall/redirect performance counters.

## Interface
- NSTAGE, 4, pipeline registers (0=IF/ID … NSTAGE-1=MEM/WB); legal ≥3
- REG_AW, 5, register-address width
- CNT_W, 32, performance counter width
- EXC_VECTOR, 32'h80000000, exception entry PC
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- id_jmp  in  1  J/JAL decoded in ID
- mem_jr  in  1  JR resolved in MEM
- mem_branch_state  in  1  taken branch resolved in MEM
- mem_stall  in  1  memory not ready
- mem_excepttype  in  32  exception code in MEM (0 = none)
- mem_pc  in  32  PC of instruction in MEM
- idex_mem_r  in  1  ID/EX holds a load
- ifid_rs_addr, ifid_rt_addr  in  REG_AW  ID source registers
- idex_rd_addr  in  REG_AW  load destination
- resume  in  1  release HALT
- cnt_clr  in  1  synchronous counter clear
- stall  out  NSTAGE+1  bit0=PC, bit i+1=pipeline register i
- flush  out  NSTAGE  bit i=pipeline register i
- pc_src  out  3  0 jump, 1 except, 2 eret, 3 control hazard, 4 PC+4
- vector  out  32  target for pc_src 1/2
- epc  out  32  captured exception PC
- halted  out  1  in HALT
- stall_cnt, redir_cnt  out  CNT_W  counters

## Operation
- States: RUN, HALT. Registered: state, epc, counters. All other outputs combinational from state and inputs.
- Defaults each cycle: stall=0, flush=0, pc_src=4, vector=0.
- reset asserted: flush all NSTAGE bits, stall=0, pc_src=4; state→RUN, epc→0, counters→0.
- HALT: stall all NSTAGE+1 bits, halted=1. On resume=1: stall=0, pc_src=1, vector=EXC_VECTOR, flush[NSTAGE-2:0]; next state RUN. All other inputs ignored.
- RUN priority, first match wins:
  1. mem_stall: stall all NSTAGE+1 bits. Pending exception is held in MEM and serviced after stall drops.
  2. mem_excepttype==0xD (eret): pc_src=2, vector=epc, flush[NSTAGE-2:0].
  3. mem_excepttype==0xA (RI): epc←mem_pc, flush[NSTAGE-2:0], stall[0]=1; next state HALT.
  4. mem_excepttype in 0x1–0xC (else): pc_src=1, vector=EXC_VECTOR, flush[NSTAGE-2:0], epc←mem_pc.
  5. Any other nonzero code: treated as case 4.
  6. mem_branch_state or mem_jr: pc_src=3, flush[1:0].
  7. id_jmp: pc_src=0, no flush.
  8. Load-use: idex_mem_r && idex_rd_addr≠0 && (ifid_rs_addr==idex_rd_addr || ifid_rt_addr==idex_rd_addr): stall[1:0], flush[1].
- stall_cnt +1 every cycle stall[0]=1 (reset excluded). redir_cnt +1 per cycle pc_src∈{1,2,3} (jump excluded). Both saturate at all-ones; cnt_clr zeroes both, overriding increment.

## Timing
- Stall/flush/pc_src/vector valid same cycle as triggering inputs; zero latency.
- epc updates at edge ending the exception cycle; vector for eret in that same cycle uses old epc.
- HALT entered the edge after RI cycle; resume acts combinationally within HALT; RUN resumes next edge.
- resume in RUN ignored. reset mid-HALT → RUN immediately (asynchronous).
- Exception simultaneous with branch: exception wins, branch redirect dropped.
- Load-use against register 0 never stalls.

## Test plan
- Load-use: idex_mem_r=1, idex_rd=5, ifid_rs=5 → stall=5'b00011, flush=4'b0010; rd=0, rs=0 → no stall.
- Exception under stall: excepttype=0x9, mem_stall=1 for 3 cycles → stall=5'b11111, stall_cnt=3; stall drops → pc_src=1, vector=0x80000000, flush=4'b0111, epc=mem_pc.
- Eret: after syscall at mem_pc=0x00400020, excepttype=0xD → pc_src=2, vector=0x00400020, redir_cnt=2.
- RI halt: excepttype=0xA, mem_pc=0x100 → next cycle halted=1, stall all for 5 cycles; resume → pc_src=1, vector=0x80000000, halted=0 next cycle.
- Priority: mem_branch_state=1 with excepttype=0xB → pc_src=1; branch with id_jmp → pc_src=3, flush=4'b0011.
- Reset in HALT and counter saturation (CNT_W=4): 20 stall cycles → stall_cnt=15; reset → all counters 0, state RUN, flush=4'b1111.
